// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one DataMemory port between the core load/store
// path and the loader/debug port, with a loader lock and registered read responses.
module data_mem_arbiter #(
  parameter int DATA_WIDTH_POW = 6,
  parameter int ADDR_WIDTH_POW = 6,
  localparam int DATA_WIDTH = 1 << DATA_WIDTH_POW,
  localparam int ADDR_WIDTH = 1 << ADDR_WIDTH_POW
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  core_valid_in,
  input  logic                  core_write_in,
  input  logic [ADDR_WIDTH-1:0] core_addr_in,
  input  logic [DATA_WIDTH-1:0] core_wdata_in,
  output logic                  core_ready_out,
  output logic                  core_stall_out,
  output logic                  core_rvalid_out,
  output logic [DATA_WIDTH-1:0] core_rdata_out,
  input  logic                  ldr_valid_in,
  input  logic                  ldr_write_in,
  input  logic [ADDR_WIDTH-1:0] ldr_addr_in,
  input  logic [DATA_WIDTH-1:0] ldr_wdata_in,
  input  logic                  ldr_lock_in,
  output logic                  ldr_ready_out,
  output logic                  ldr_rvalid_out,
  output logic [DATA_WIDTH-1:0] ldr_rdata_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

  typedef enum logic {ST_SHARED, ST_LOCKED} state_e;
  typedef enum logic {GR_CORE, GR_LDR} grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  grant_core, grant_ldr;
  logic                  core_rvalid_q, core_rvalid_d;
  logic                  ldr_rvalid_q, ldr_rvalid_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_core   = 1'b0;
    grant_ldr    = 1'b0;
    case (state_q)
      ST_SHARED: begin
        if (core_valid_in && ldr_valid_in) begin
          grant_core = (last_grant_q == GR_LDR);
          grant_ldr  = (last_grant_q == GR_CORE);
        end else begin
          grant_core = core_valid_in;
          grant_ldr  = ldr_valid_in;
        end
        if (ldr_lock_in) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        grant_ldr = ldr_valid_in;
        if (!ldr_lock_in) state_d = ST_SHARED;
      end
      default: state_d = ST_SHARED;
    endcase
    // Nothing is granted while reset is held, which also silences the memory port.
    if (reset) begin
      grant_core = 1'b0;
      grant_ldr  = 1'b0;
    end
    if (state_q == ST_SHARED) begin
      if (grant_core) last_grant_d = GR_CORE;
      if (grant_ldr)  last_grant_d = GR_LDR;
    end
  end

  always_comb begin
    mem_read_out  = 1'b0;
    mem_write_out = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    if (grant_core) begin
      mem_read_out  = ~core_write_in;
      mem_write_out = core_write_in;
      mem_addr_out  = core_addr_in;
      mem_wdata_out = core_wdata_in;
    end else if (grant_ldr) begin
      mem_read_out  = ~ldr_write_in;
      mem_write_out = ldr_write_in;
      mem_addr_out  = ldr_addr_in;
      mem_wdata_out = ldr_wdata_in;
    end
  end

  always_comb begin
    core_rvalid_d = grant_core & ~core_write_in;
    ldr_rvalid_d  = grant_ldr & ~ldr_write_in;
    core_rdata_d  = core_rvalid_d ? mem_rdata_in : core_rdata_q;
    ldr_rdata_d   = ldr_rvalid_d ? mem_rdata_in : ldr_rdata_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SHARED;
      last_grant_q  <= GR_LDR;
      core_rvalid_q <= 1'b0;
      ldr_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      ldr_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      core_rvalid_q <= core_rvalid_d;
      ldr_rvalid_q  <= ldr_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      ldr_rdata_q   <= ldr_rdata_d;
    end
  end

  assign core_ready_out  = grant_core;
  assign core_stall_out  = core_valid_in & ~grant_core;
  assign ldr_ready_out   = grant_ldr;
  assign core_rvalid_out = core_rvalid_q;
  assign core_rdata_out  = core_rdata_q;
  assign ldr_rvalid_out  = ldr_rvalid_q;
  assign ldr_rdata_out   = ldr_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a small memory, a rule-level arbitration model
// checked every cycle, and directed scenarios with literal expectations.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_valid, core_write, core_ready, core_stall, core_rvalid;
  logic [63:0] core_addr, core_wdata, core_rdata;
  logic        ldr_valid, ldr_write, ldr_lock, ldr_ready, ldr_rvalid;
  logic [63:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] tb_mem [0:255];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk_in(clk), .reset(rst),
    .core_valid_in(core_valid), .core_write_in(core_write),
    .core_addr_in(core_addr), .core_wdata_in(core_wdata),
    .core_ready_out(core_ready), .core_stall_out(core_stall),
    .core_rvalid_out(core_rvalid), .core_rdata_out(core_rdata),
    .ldr_valid_in(ldr_valid), .ldr_write_in(ldr_write),
    .ldr_addr_in(ldr_addr), .ldr_wdata_in(ldr_wdata), .ldr_lock_in(ldr_lock),
    .ldr_ready_out(ldr_ready), .ldr_rvalid_out(ldr_rvalid), .ldr_rdata_out(ldr_rdata),
    .mem_read_out(mem_read), .mem_write_out(mem_write),
    .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata)
  );

  // DataMemory stand-in: combinational read, write at the clock edge.
  assign mem_rdata = mem_read ? tb_mem[mem_addr[7:0]] : 64'h0;
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[7:0]] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who may be served is decided from the requests alone.
  bit          m_locked = 1'b0;
  bit          m_last_ldr = 1'b1;
  bit          m_core_rvalid = 1'b0, m_ldr_rvalid = 1'b0;
  logic [63:0] m_core_rdata = '0, m_ldr_rdata = '0;

  function automatic logic [1:0] model_grant();  // {core, ldr}
    if (rst) return 2'b00;
    if (m_locked) return {1'b0, ldr_valid};
    if (core_valid && ldr_valid) return m_last_ldr ? 2'b10 : 2'b01;
    return {core_valid, ldr_valid};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0] g;
    if (rst) begin
      m_locked      <= 1'b0;
      m_last_ldr    <= 1'b1;
      m_core_rvalid <= 1'b0;
      m_ldr_rvalid  <= 1'b0;
      m_core_rdata  <= '0;
      m_ldr_rdata   <= '0;
    end else begin
      g = model_grant();
      if (!m_locked && g != 2'b00) m_last_ldr <= g[0];
      m_core_rvalid <= g[1] && !core_write;
      m_ldr_rvalid  <= g[0] && !ldr_write;
      if (g[1] && !core_write) m_core_rdata <= tb_mem[core_addr[7:0]];
      if (g[0] && !ldr_write)  m_ldr_rdata  <= tb_mem[ldr_addr[7:0]];
      m_locked <= ldr_lock;
    end
  end

  always @(negedge clk) begin
    logic [1:0]  g;
    logic        er, ew;
    logic [63:0] ea, ed;
    g = model_grant();
    er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
    if (g[1]) begin
      er = !core_write; ew = core_write; ea = core_addr; ed = core_wdata;
    end else if (g[0]) begin
      er = !ldr_write; ew = ldr_write; ea = ldr_addr; ed = ldr_wdata;
    end
    check("core_ready", core_ready, g[1]);
    check("ldr_ready", ldr_ready, g[0]);
    check("core_stall", core_stall, core_valid && !g[1]);
    check("mem_read", mem_read, er);
    check("mem_write", mem_write, ew);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    check("core_rvalid", core_rvalid, m_core_rvalid);
    check("ldr_rvalid", ldr_rvalid, m_ldr_rvalid);
    check("core_rdata", core_rdata, m_core_rdata);
    check("ldr_rdata", ldr_rdata, m_ldr_rdata);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat;
    int stalls, idx, cyc, core_g;
    bit adv;

    core_valid = 0; core_write = 0; core_addr = '0; core_wdata = '0;
    ldr_valid = 0; ldr_write = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    tb_mem[8'h10] = 64'hDEAD_BEEF;

    // Requests during reset are ignored.
    next_cycle();
    core_valid = 1; ldr_valid = 1;
    @(negedge clk);
    check("rst_core_ready", core_ready, 0);
    check("rst_ldr_ready", ldr_ready, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_core_rvalid", core_rvalid, 0);
    next_cycle();
    core_valid = 0; ldr_valid = 0; rst = 0;

    // Core load from 0x10.
    core_valid = 1; core_write = 0; core_addr = 64'h10;
    @(negedge clk);
    check("t1_ready", core_ready, 1);
    check("t1_mem_read", mem_read, 1);
    check("t1_mem_addr", mem_addr, 64'h10);
    next_cycle();
    core_valid = 0;
    @(negedge clk);
    check("t1_rvalid", core_rvalid, 1);
    check("t1_rdata", core_rdata, 64'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("t1_rvalid_once", core_rvalid, 0);
    check("t1_rdata_hold", core_rdata, 64'hDEAD_BEEF);

    // Loader store then core load of the same address.
    next_cycle();
    ldr_valid = 1; ldr_write = 1; ldr_addr = 64'h40; ldr_wdata = 64'h1234;
    @(negedge clk);
    check("t4_ldr_ready", ldr_ready, 1);
    check("t4_mem_write", mem_write, 1);
    next_cycle();
    ldr_valid = 0; core_valid = 1; core_write = 0; core_addr = 64'h40;
    @(negedge clk);
    check("t4_core_ready", core_ready, 1);
    check("t4_no_ldr_rvalid_a", ldr_rvalid, 0);
    next_cycle();
    core_valid = 0;
    @(negedge clk);
    check("t4_core_rdata", core_rdata, 64'h1234);
    check("t4_no_ldr_rvalid_b", ldr_rvalid, 0);

    // Loader load, leaving the loader as the most recent winner.
    next_cycle();
    ldr_valid = 1; ldr_write = 0; ldr_addr = 64'h40;
    @(negedge clk);
    check("ldr_load_ready", ldr_ready, 1);
    next_cycle();
    ldr_valid = 0;
    @(negedge clk);
    check("ldr_load_rdata", ldr_rdata, 64'h1234);

    // Round-robin with both requesters continuously valid.
    next_cycle();
    core_valid = 1; core_write = 0; core_addr = 64'h10;
    ldr_valid = 1; ldr_write = 0; ldr_addr = 64'h40;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = core_ready;
      if (core_stall) stalls++;
      next_cycle();
    end
    check("rr_pattern", 64'(pat), 64'(6'b010101));
    check("rr_stalls", 64'(stalls), 64'd3);

    // Lock: loader issues four stores while the core keeps requesting.
    ldr_write = 1; ldr_lock = 1; idx = 0; cyc = 0; core_g = 0;
    ldr_addr = 64'h0; ldr_wdata = 64'hA0;
    while (idx < 4 && cyc < 12) begin
      @(negedge clk);
      if (core_ready) core_g++;
      adv = ldr_ready;
      next_cycle();
      cyc++;
      if (adv) begin
        idx++;
        ldr_addr  = 64'(idx * 8);
        ldr_wdata = 64'(32'hA0 + idx);
      end
    end
    check("lock_cycles", 64'(cyc), 64'd5);
    check("lock_core_grants", 64'(core_g), 64'd1);
    ldr_lock = 0; ldr_valid = 0;
    @(negedge clk);
    check("unlock_same_cycle", core_ready, 0);
    check("unlock_stall", core_stall, 1);
    next_cycle();
    @(negedge clk);
    check("unlock_next_cycle", core_ready, 1);
    next_cycle();
    core_valid = 0;
    ldr_valid = 1; ldr_write = 0; ldr_addr = 64'h18;
    @(negedge clk);
    next_cycle();
    ldr_valid = 0;
    @(negedge clk);
    check("lock_store_data", ldr_rdata, 64'hA3);

    // Reset in the cycle after an accepted core read.
    next_cycle();
    core_valid = 1; core_write = 0; core_addr = 64'h40;
    @(negedge clk);
    check("t5_accept", core_ready, 1);
    next_cycle();
    #1;
    check("t5_rvalid_before", core_rvalid, 1);
    rst = 1;
    #1;
    check("t5_rvalid_cleared", core_rvalid, 0);
    check("t5_rdata_cleared", core_rdata, 0);
    check("t5_mem_read", mem_read, 0);
    check("t5_core_ready", core_ready, 0);
    next_cycle();
    rst = 0;
    ldr_valid = 1; ldr_write = 0; ldr_addr = 64'h10;
    @(negedge clk);
    check("t5_tie_core", core_ready, 1);
    check("t5_tie_ldr", ldr_ready, 0);
    check("t5_no_stale_rvalid", core_rvalid, 0);
    next_cycle();
    core_valid = 0; ldr_valid = 0;
    @(negedge clk);
    next_cycle();

    // Idle requesters.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_mem", {mem_read, mem_write, mem_addr[0], mem_wdata[0]}, 0);
      check("idle_addr", mem_addr | mem_wdata, 0);
      check("idle_rvalid", {core_rvalid, ldr_rvalid}, 0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
